// File: rtl/oldestn_pkg.sv
// Shared helpers for the oldest-first grant buffer.
package oldestn_pkg;

  localparam int unsigned IDX_BUS_MAX = 256;
  localparam int unsigned IDX_MAX     = 16;

  // Ceiling log2 for parameter arithmetic; returns 0 for n <= 1.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Extract field k of width w from a packed index bus.
  function automatic logic [IDX_MAX-1:0] idx_field(input logic [IDX_BUS_MAX-1:0] bus,
                                                   input int unsigned k,
                                                   input int unsigned w);
    logic [IDX_BUS_MAX-1:0] mask;
    mask = (IDX_BUS_MAX'(1) << w) - IDX_BUS_MAX'(1);
    return IDX_MAX'((bus >> (k * w)) & mask);
  endfunction

endpackage

// File: rtl/oldestn_pick.sv
// Oldest-first multi-pick: rotate candidates, peel lowest set bits, rotate indices back.
module oldestn_pick
  import oldestn_pkg::*;
#(
  parameter int unsigned SEL_WIDTH      = 16,
  parameter int unsigned PRIORITY_WIDTH = clog2_f(SEL_WIDTH),
  parameter int unsigned GRANT_NUM      = 2,
  localparam int unsigned CNT_W         = clog2_f(GRANT_NUM + 1)
) (
  input  logic [SEL_WIDTH-1:0]                cand,
  input  logic [PRIORITY_WIDTH-1:0]           priority_fix,
  input  logic [CNT_W-1:0]                    free_cnt,
  output logic [GRANT_NUM-1:0]                pick_valid,
  output logic [GRANT_NUM*PRIORITY_WIDTH-1:0] pick_index
);

  localparam logic [PRIORITY_WIDTH:0] SEL_EXT = (PRIORITY_WIDTH + 1)'(SEL_WIDTH);

  logic [2*SEL_WIDTH-1:0]    dbl;
  logic [SEL_WIDTH-1:0]      rem;
  logic                      found;
  logic [PRIORITY_WIDTH-1:0] pos;
  logic [PRIORITY_WIDTH:0]   sum;

  // Each pick takes the lowest remaining bit of the age-rotated vector, then masks it off.
  always_comb begin
    dbl        = {cand, cand} >> priority_fix;
    rem        = dbl[SEL_WIDTH-1:0];
    pick_valid = '0;
    pick_index = '0;
    found      = 1'b0;
    pos        = '0;
    sum        = '0;
    for (int j = 0; j < GRANT_NUM; j++) begin
      found = 1'b0;
      pos   = '0;
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (!found && rem[b]) begin
          found = 1'b1;
          pos   = PRIORITY_WIDTH'(b);
        end
      end
      if (found && (CNT_W'(j) < free_cnt)) begin
        pick_valid[j] = 1'b1;
        rem[pos]      = 1'b0;
        sum           = {1'b0, pos} + {1'b0, priority_fix};
        if (sum >= SEL_EXT) sum = sum - SEL_EXT;
        pick_index[j*PRIORITY_WIDTH +: PRIORITY_WIDTH] = PRIORITY_WIDTH'(sum);
      end
    end
  end

endmodule

// File: rtl/oldestn_grant_buffer.sv
// N-way oldest-first arbiter with registered, handshaked grant slots.
module oldestn_grant_buffer
  import oldestn_pkg::*;
#(
  parameter int unsigned SEL_WIDTH      = 16,
  parameter int unsigned PRIORITY_WIDTH = clog2_f(SEL_WIDTH),
  parameter int unsigned GRANT_NUM      = 2,
  localparam int unsigned CNT_W         = clog2_f(GRANT_NUM + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic [PRIORITY_WIDTH-1:0]           priority_fix_i,
  input  logic [SEL_WIDTH-1:0]                req_i,
  input  logic [GRANT_NUM-1:0]                grant_ready_i,
  output logic [GRANT_NUM-1:0]                grant_valid_o,
  output logic [GRANT_NUM*PRIORITY_WIDTH-1:0] grant_index_o,
  output logic [SEL_WIDTH-1:0]                accept_mask_o,
  output logic [SEL_WIDTH-1:0]                pending_mask_o
);

  logic [GRANT_NUM-1:0]                valid_q, valid_d;
  logic [PRIORITY_WIDTH-1:0]           index_q [GRANT_NUM];
  logic [PRIORITY_WIDTH-1:0]           index_d [GRANT_NUM];
  logic [GRANT_NUM-1:0]                fire, free;
  logic [CNT_W-1:0]                    free_cnt;
  logic [SEL_WIDTH-1:0]                cand;
  logic [GRANT_NUM-1:0]                pick_valid;
  logic [GRANT_NUM*PRIORITY_WIDTH-1:0] pick_index;
  logic                                pv;
  logic [PRIORITY_WIDTH-1:0]           pi;
  int                                  p;

  // Held/accepted masks, free-slot count and candidates; firing slots still count as pending.
  always_comb begin
    fire           = valid_q & grant_ready_i;
    free           = ~valid_q | fire;
    pending_mask_o = '0;
    accept_mask_o  = '0;
    free_cnt       = '0;
    for (int k = 0; k < GRANT_NUM; k++) begin
      if (valid_q[k]) pending_mask_o[index_q[k]] = 1'b1;
      if (fire[k])    accept_mask_o[index_q[k]]  = 1'b1;
      if (free[k])    free_cnt = free_cnt + CNT_W'(1);
    end
    cand = req_i & ~pending_mask_o;
  end

  oldestn_pick #(
    .SEL_WIDTH      (SEL_WIDTH),
    .PRIORITY_WIDTH (PRIORITY_WIDTH),
    .GRANT_NUM      (GRANT_NUM)
  ) u_pick (
    .cand         (cand),
    .priority_fix (priority_fix_i),
    .free_cnt     (free_cnt),
    .pick_valid   (pick_valid),
    .pick_index   (pick_index)
  );

  // Compact picks onto free slots in ascending order; flush empties every slot.
  always_comb begin
    valid_d = valid_q;
    index_d = index_q;
    p       = 0;
    pv      = 1'b0;
    pi      = '0;
    for (int k = 0; k < GRANT_NUM; k++) begin
      if (free[k]) begin
        pv = 1'b0;
        pi = '0;
        for (int j = 0; j < GRANT_NUM; j++) begin
          if (j == p) begin
            pv = pick_valid[j];
            pi = PRIORITY_WIDTH'(idx_field(IDX_BUS_MAX'(pick_index), j, PRIORITY_WIDTH));
          end
        end
        valid_d[k] = pv;
        if (pv) index_d[k] = pi;
        p = p + 1;
      end
    end
    if (flush_i) valid_d = '0;
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < GRANT_NUM; k++) index_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < GRANT_NUM; k++) index_q[k] <= index_d[k];
    end
  end

  // Pack slot registers onto the output bus.
  always_comb begin
    grant_valid_o = valid_q;
    grant_index_o = '0;
    for (int k = 0; k < GRANT_NUM; k++) begin
      grant_index_o[k*PRIORITY_WIDTH +: PRIORITY_WIDTH] = index_q[k];
    end
  end

endmodule

// File: tb/tb_oldestn_grant_buffer.sv
// Randomized and directed bench for oldestn_grant_buffer against an age-queue model.
module tb_oldestn_grant_buffer;

  localparam int unsigned SW = 16;
  localparam int unsigned PW = 4;
  localparam int unsigned GN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic [PW-1:0] priority_fix_i;
  logic [SW-1:0] req_i;
  logic [GN-1:0] grant_ready_i;
  logic [GN-1:0] grant_valid_o;
  logic [GN*PW-1:0] grant_index_o;
  logic [SW-1:0] accept_mask_o;
  logic [SW-1:0] pending_mask_o;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: one entry per slot
  bit     mvalid [GN];
  int     midx   [GN];
  logic [SW-1:0] obs_accept;

  oldestn_grant_buffer #(.SEL_WIDTH(SW), .PRIORITY_WIDTH(PW), .GRANT_NUM(GN)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .priority_fix_i (priority_fix_i),
    .req_i          (req_i),
    .grant_ready_i  (grant_ready_i),
    .grant_valid_o  (grant_valid_o),
    .grant_index_o  (grant_index_o),
    .accept_mask_o  (accept_mask_o),
    .pending_mask_o (pending_mask_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slot_idx(input int k);
    logic [GN*PW-1:0] bus;
    bus = grant_index_o;
    return int'(bus[k*PW +: PW]);
  endfunction

  // Compare all DUT outputs with the model for the current (pre-edge) cycle.
  task automatic compare_now();
    logic [SW-1:0] exp_pend, exp_acc;
    exp_pend = '0;
    exp_acc  = '0;
    for (int k = 0; k < GN; k++) begin
      if (mvalid[k]) exp_pend[midx[k]] = 1'b1;
      if (mvalid[k] && grant_ready_i[k]) exp_acc[midx[k]] = 1'b1;
    end
    check("pending", 32'(pending_mask_o), 32'(exp_pend));
    check("accept", 32'(accept_mask_o), 32'(exp_acc));
    for (int k = 0; k < GN; k++) begin
      check($sformatf("valid%0d", k), 32'(grant_valid_o[k]), 32'(mvalid[k]));
      if (mvalid[k]) check($sformatf("index%0d", k), 32'(slot_idx(k)), 32'(midx[k]));
    end
  endtask

  // One cycle: drive, compare, compute model next state, advance past the edge.
  task automatic step(input logic [SW-1:0] req, input logic [PW-1:0] prio,
                      input logic [GN-1:0] rdy, input logic fl, input logic rs);
    bit            nv [GN];
    int            ni [GN];
    int            q [$];
    logic [SW-1:0] pend;
    int            e;
    @(negedge clk);
    req_i = req; priority_fix_i = prio; grant_ready_i = rdy; flush_i = fl; rst = rs;
    #1;
    compare_now();
    obs_accept = accept_mask_o;
    pend = '0;
    for (int k = 0; k < GN; k++) if (mvalid[k]) pend[midx[k]] = 1'b1;
    for (int a = 0; a < SW; a++) begin
      e = (int'(prio) + a) % SW;
      if (req[e] && !pend[e]) q.push_back(e);
    end
    for (int k = 0; k < GN; k++) begin
      nv[k] = mvalid[k];
      ni[k] = midx[k];
      if (rs) begin
        nv[k] = 1'b0; ni[k] = 0;
      end else if (fl) begin
        nv[k] = 1'b0;
      end else if (!mvalid[k] || rdy[k]) begin
        if (q.size() > 0) begin
          nv[k] = 1'b1; ni[k] = q.pop_front();
        end else begin
          nv[k] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < GN; k++) begin
      mvalid[k] = nv[k];
      midx[k]   = ni[k];
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; priority_fix_i = '0; req_i = '0; grant_ready_i = '0;
    for (int k = 0; k < GN; k++) begin mvalid[k] = 1'b0; midx[k] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(grant_valid_o), 32'h0);
    check("rst_index", 32'(grant_index_o), 32'h0);
    check("rst_accept", 32'(accept_mask_o), 32'h0);
    check("rst_pending", 32'(pending_mask_o), 32'h0);

    // wrap pick
    step(16'h8001, 4'd15, 2'b11, 1'b0, 1'b0);
    check("wrap_s0", 32'(slot_idx(0)), 32'd15);
    check("wrap_s1", 32'(slot_idx(1)), 32'd0);
    check("wrap_acc", 32'(accept_mask_o), 32'h8001);
    step(16'h0000, 4'd0, 2'b11, 1'b0, 1'b0);

    // hold under stall
    for (int i = 0; i < 4; i++) step(16'h00F0, 4'd0, 2'b00, 1'b0, 1'b0);
    check("hold_s0", 32'(slot_idx(0)), 32'd4);
    check("hold_s1", 32'(slot_idx(1)), 32'd5);
    check("hold_pend", 32'(pending_mask_o), 32'h0030);

    // partial accept
    step(16'h00F0, 4'd0, 2'b10, 1'b0, 1'b0);
    check("part_s0", 32'(slot_idx(0)), 32'd4);
    check("part_s1", 32'(slot_idx(1)), 32'd6);
    step(16'h00D0, 4'd0, 2'b01, 1'b0, 1'b0);
    check("part2_s0", 32'(slot_idx(0)), 32'd7);
    check("part2_s1", 32'(slot_idx(1)), 32'd6);

    // sparse requests
    step(16'h0000, 4'd0, 2'b11, 1'b0, 1'b0);
    step(16'h0100, 4'd0, 2'b00, 1'b0, 1'b0);
    check("sparse_v", 32'(grant_valid_o), 32'h1);
    check("sparse_s0", 32'(slot_idx(0)), 32'd8);

    // flush during fire
    step(16'h0000, 4'd0, 2'b11, 1'b0, 1'b0);
    step(16'h000C, 4'd0, 2'b00, 1'b0, 1'b0);
    step(16'h000C, 4'd0, 2'b01, 1'b1, 1'b0);
    check("flush_acc", 32'(obs_accept), 32'h0004);
    check("flush_v", 32'(grant_valid_o), 32'h0);

    // reset mid-operation
    step(16'h000C, 4'd0, 2'b00, 1'b0, 1'b0);
    step(16'h000C, 4'd0, 2'b00, 1'b0, 1'b1);
    check("mrst_v", 32'(grant_valid_o), 32'h0);
    check("mrst_idx", 32'(grant_index_o), 32'h0);
    step(16'h0030, 4'd0, 2'b00, 1'b0, 1'b0);
    check("resume_s0", 32'(slot_idx(0)), 32'd4);
    check("resume_s1", 32'(slot_idx(1)), 32'd5);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(SW'($urandom) & SW'($urandom | $urandom), PW'($urandom),
           GN'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end
    step(16'h0000, 4'd0, 2'b00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
